// File: rtl/filter_cmd_pkg.sv
// rtl/filter_cmd_pkg.sv - shared states, codes, button patterns and decode for the filter command arbiter
package filter_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] FILT_BYPASS = 2'd0;
    localparam logic [1:0] FILT_1      = 2'd1;
    localparam logic [1:0] FILT_2      = 2'd2;

    // Buttons are active-low: a single 0 bit marks the pressed button
    localparam logic [2:0] BTN_F1  = 3'b110;
    localparam logic [2:0] BTN_F2  = 3'b101;
    localparam logic [2:0] BTN_BYP = 3'b011;
    localparam logic [2:0] BTN_REL = 3'b111;

    localparam logic [31:0] MAILBOX_ADDR_DEF = 32'd10000;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } cmd_t;

    // Single-button patterns map to a filter code; release and chords do not
    function automatic cmd_t decode_btn(input logic [2:0] pat);
        cmd_t c;
        c.valid = 1'b1;
        c.code  = FILT_BYPASS;
        case (pat)
            BTN_F1:  c.code = FILT_1;
            BTN_F2:  c.code = FILT_2;
            BTN_BYP: c.code = FILT_BYPASS;
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop button synchronizer with stability counter producing the accepted pattern
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_btn,
    output logic [2:0] o_accepted
);
    import filter_cmd_pkg::*;

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The cycle that loads the candidate already counts as one stable cycle,
    // so the counter only has to climb to DEBOUNCE_CYCLES-2 before accepting.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_cand;
    logic [2:0]    r_accepted;
    logic [CW-1:0] r_cnt;

    // Synchronize raw buttons, track a candidate, and accept it once stable long enough
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= BTN_REL;
            r_sync2    <= BTN_REL;
            r_cand     <= BTN_REL;
            r_accepted <= BTN_REL;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_accepted <= r_cand;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_accepted = r_accepted;

endmodule

// File: rtl/filter_cmd_arbiter.sv
// rtl/filter_cmd_arbiter.sv - memory write-port arbiter between CPU and debounced filter buttons (optional FILTER_CMD_STARVE_GUARD_EN)
module filter_cmd_arbiter #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] MAILBOX_ADDR    = 32'd10000,
    parameter int          MAX_WAIT        = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_btn,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic        o_cpu_stall,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_cmd_code,
    output logic        o_cmd_done
);
    import filter_cmd_pkg::*;

    logic [2:0] w_accepted;
    cmd_t       w_cmd;
    logic       w_grant;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_pend_code;
    logic [1:0] r_cmd_code;
    logic       r_cmd_done;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn      (i_btn),
        .o_accepted (w_accepted)
    );

    assign w_cmd = decode_btn(w_accepted);

`ifdef FILTER_CMD_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] r_wait;
    logic          w_starve;

    assign w_starve    = (r_state == PEND) && (r_wait == WW'(MAX_WAIT));
    assign o_cpu_stall = w_starve && i_cpu_we;
    assign w_grant     = (r_state == PEND) && (!i_cpu_we || w_starve);

    // Count cycles spent waiting in PEND; a grant or leaving PEND clears it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= '0;
        end else if ((r_state != PEND) || w_grant) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + WW'(1);
        end
    end
`else
    logic w_unused_max_wait;

    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign o_cpu_stall       = 1'b0;
    assign w_grant           = (r_state == PEND) && !i_cpu_we;
`endif

    // State register and pending-code latch taken on the IDLE->PEND transition
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pend_code <= FILT_BYPASS;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_cmd.valid) begin
                r_pend_code <= w_cmd.code;
            end
        end
    end

    // Next state: one command per press, re-armed only by a full release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cmd.valid) w_state_nxt = PEND;
            PEND:    if (w_grant) w_state_nxt = HOLD;
            HOLD:    if (w_accepted == BTN_REL) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Record the granted code and pulse done in the following cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_code <= FILT_BYPASS;
            r_cmd_done <= 1'b0;
        end else begin
            r_cmd_done <= w_grant;
            if (w_grant) begin
                r_cmd_code <= r_pend_code;
            end
        end
    end

    // Write-port mux: the mailbox write overrides the CPU only when granted
    always_comb begin
        o_mem_we    = i_cpu_we;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        if (w_grant) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = MAILBOX_ADDR;
            o_mem_wdata = {30'd0, r_pend_code};
        end
    end

    assign o_cmd_code = r_cmd_code;
    assign o_cmd_done = r_cmd_done;

endmodule

// File: tb/tb_filter_cmd_arbiter.sv
// tb/tb_filter_cmd_arbiter.sv - directed self-checking bench for filter_cmd_arbiter
module tb_filter_cmd_arbiter;

    localparam int          DEB  = 16;
    localparam logic [31:0] MBOX = 32'd10000;
    localparam int          MAXW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  btn;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  cmd_code;
    logic        cmd_done;

    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    logic        s_we, s_stall, s_done;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] mb_q[$];

    always #5 clk = ~clk;

    filter_cmd_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .MAILBOX_ADDR   (MBOX),
        .MAX_WAIT       (MAXW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn       (btn),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_stall (cpu_stall),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cmd_code  (cmd_code),
        .o_cmd_done  (cmd_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Sample the current cycle's outputs, then advance to 1 time unit past the next edge
    task automatic tick();
        #1;
        s_we    = mem_we;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
        s_stall = cpu_stall;
        s_done  = cmd_done;
        if (s_we && (s_addr == MBOX)) mb_q.push_back(s_wdata);
        if (s_done) done_cnt++;
        if (s_stall) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    int lat, dlat, errs, st;
    logic        st_we;
    logic [31:0] st_addr, st_data;

    initial begin
        rst_n     = 1'b0;
        btn       = 3'b111;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h1234;
        cpu_wdata = 32'hCAFE0001;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_mem_addr", mem_addr, 32'h1234);
        check_eq("rst_mem_wdata", mem_wdata, 32'hCAFE0001);
        check_eq("rst_cmd_code", 32'(cmd_code), 0);
        check_eq("rst_cmd_done", 32'(cmd_done), 0);
        check_eq("rst_cpu_stall", 32'(cpu_stall), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short glitch must not produce a command
        mb_q.delete();
        btn = 3'b101;
        repeat (10) tick();
        btn = 3'b111;
        repeat (30) tick();
        check_eq("glitch_writes", 32'(mb_q.size()), 0);
        check_eq("glitch_code", 32'(cmd_code), 0);

        // Single press: latency 19 cycles, data 1, one done pulse the cycle after
        mb_q.delete();
        done_cnt = 0;
        lat = -1;
        dlat = -1;
        btn = 3'b110;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (lat < 0 && mb_q.size() > 0) lat = i;
            if (dlat < 0 && s_done) dlat = i;
        end
        check_eq("press_latency", 32'(lat), 19);
        check_eq("press_done_cycle", 32'(dlat), 20);
        check_eq("press_writes", 32'(mb_q.size()), 1);
        check_eq("press_data", (mb_q.size() > 0) ? mb_q[0] : 32'hFFFFFFFF, 1);
        check_eq("press_done_cnt", 32'(done_cnt), 1);
        check_eq("press_code", 32'(cmd_code), 1);
        btn = 3'b111;
        repeat (25) tick();

        // Processor writes take priority; mailbox write in the first idle cycle
        mb_q.delete();
        done_cnt = 0;
        stall_cnt = 0;
        errs = 0;
        cpu_we = 1'b1;
        btn = 3'b101;
        for (int i = 0; i < 30; i++) begin
            cpu_addr  = 32'h100 + i;
            cpu_wdata = 32'hA5000000 + i;
            tick();
            if (!(s_we && s_addr == cpu_addr && s_wdata == cpu_wdata)) errs++;
        end
        check_eq("cpu_pass_errs", 32'(errs), 0);
        check_eq("cpu_no_mbox", 32'(mb_q.size()), 0);
        check_eq("cpu_no_stall", 32'(stall_cnt), 0);
        cpu_we = 1'b0;
        tick();
        check_eq("grant_we", 32'(s_we), 1);
        check_eq("grant_addr", s_addr, MBOX);
        check_eq("grant_data", s_wdata, 2);
        tick();
        check_eq("grant_done", 32'(s_done), 1);
        check_eq("grant_code", 32'(cmd_code), 2);
        btn = 3'b111;
        repeat (25) tick();
        check_eq("grant_done_cnt", 32'(done_cnt), 1);

        // Change buttons without release, then release and press again
        mb_q.delete();
        btn = 3'b110;
        repeat (30) tick();
        btn = 3'b011;
        repeat (30) tick();
        btn = 3'b111;
        repeat (25) tick();
        btn = 3'b011;
        repeat (30) tick();
        btn = 3'b111;
        repeat (25) tick();
        check_eq("seq_writes", 32'(mb_q.size()), 2);
        check_eq("seq_data0", (mb_q.size() > 0) ? mb_q[0] : 32'hFFFFFFFF, 1);
        check_eq("seq_data1", (mb_q.size() > 1) ? mb_q[1] : 32'hFFFFFFFF, 0);
        check_eq("seq_code", 32'(cmd_code), 0);

`ifdef FILTER_CMD_STARVE_GUARD_EN
        // Starvation guard forces the mailbox write after MAX_WAIT cycles in PEND
        mb_q.delete();
        stall_cnt = 0;
        st = -1;
        st_we = 1'b0;
        st_addr = '0;
        st_data = '0;
        cpu_we = 1'b1;
        btn = 3'b110;
        for (int i = 0; i < 120; i++) begin
            cpu_addr  = 32'h300 + i;
            cpu_wdata = 32'h5A000000 + i;
            tick();
            if (s_stall && st < 0) begin
                st = i;
                st_we = s_we;
                st_addr = s_addr;
                st_data = s_wdata;
            end
        end
        check_eq("starve_cycle", 32'(st), 19 + MAXW);
        check_eq("starve_we", 32'(st_we), 1);
        check_eq("starve_addr", st_addr, MBOX);
        check_eq("starve_data", st_data, 1);
        check_eq("starve_stall_cnt", 32'(stall_cnt), 1);
        check_eq("starve_writes", 32'(mb_q.size()), 1);
        cpu_we = 1'b0;
        btn = 3'b111;
        repeat (25) tick();
`endif

        // Reset while a command is pending discards it
        mb_q.delete();
        done_cnt = 0;
        stall_cnt = 0;
        cpu_we = 1'b1;
        cpu_addr = 32'h200;
        cpu_wdata = 32'h77;
        btn = 3'b110;
        repeat (25) tick();
        check_eq("pend_no_write", 32'(mb_q.size()), 0);
        rst_n = 1'b0;
        cpu_we = 1'b0;
        btn = 3'b111;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check_eq("rst_pend_writes", 32'(mb_q.size()), 0);
        check_eq("rst_pend_done", 32'(done_cnt), 0);
        check_eq("rst_pend_code", 32'(cmd_code), 0);
        check_eq("rst_pend_we", 32'(mem_we), 0);
        check_eq("rst_pend_stall", 32'(stall_cnt), 0);
        check_eq("rst_pend_addr", mem_addr, 32'h200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/filter_cmd_arbiter.md
# filter_cmd_arbiter

Shares the data-memory write port between the processor and the push-button filter selector. Raw active-low buttons are synchronized and debounced, then decoded into a filter code. The code is written once per press into the filter mailbox word that the image-filter software polls. Processor writes have priority, with an optional starvation guard that forces the pending command through.

## Interface
- `DEBOUNCE_CYCLES`, 16: cycles a synchronized button pattern must stay stable before it is accepted (min 2).
- `MAILBOX_ADDR`, 10000: word address of the filter mailbox.
- `MAX_WAIT`, 64: starvation limit in cycles. Used only with the starvation guard.
- `clk  in  1`: single clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `btn  in  3`: raw push buttons, active-low, asynchronous to `clk`.
- `cpu_we  in  1`: processor write enable.
- `cpu_addr  in  32`: processor write address.
- `cpu_wdata  in  32`: processor write data.
- `cpu_stall  out  1`: the processor's write is not accepted this cycle; the processor holds the write.
- `mem_we  out  1`: memory write enable.
- `mem_addr  out  32`: memory write address.
- `mem_wdata  out  32`: memory write data.
- `cmd_code  out  2`: last filter code written to the mailbox.
- `cmd_done  out  1`: one-cycle pulse, asserted the cycle after a mailbox write.

## Operation
- **Synchronizer:** a two-flop synchronizer on each `btn` bit.
- **Debounce:**
  - A counter restarts at 0 whenever the synchronized pattern differs from the candidate pattern.
  - After `DEBOUNCE_CYCLES` consecutive stable cycles, the candidate becomes the accepted pattern.
- **Decode of the accepted pattern:**
  - 3'b110 → code 1 (filter 1).
  - 3'b101 → code 2 (filter 2).
  - 3'b011 → code 0 (bypass).
  - 3'b111 → released.
  - Any other pattern (multiple buttons pressed) → no command.
- **FSM states:** IDLE, PEND, HOLD.
  - IDLE → PEND when the accepted pattern decodes to a code. The code is latched into a pending register.
  - PEND → HOLD in the cycle the mailbox write is granted.
  - HOLD → IDLE when the accepted pattern is 3'b111. Any other pattern in HOLD, including a different button, is ignored. This gives exactly one command per press.
- **Arbitration (combinational mux, registered state):**
  - When `cpu_we` = 1: the memory port passes `cpu_addr`, `cpu_wdata` and `mem_we` = 1. A command in PEND waits.
  - When `cpu_we` = 0 and state is PEND: the port drives `mem_we` = 1, `mem_addr` = `MAILBOX_ADDR`, `mem_wdata` = zero-extended pending code. This is the grant.
  - Otherwise: `mem_we` = 0; `mem_addr` and `mem_wdata` follow the `cpu_*` inputs.
- **Grant side effects:** on a grant, `cmd_code` is updated and `cmd_done` pulses on the next cycle.
- **Reset values:** state IDLE, `cmd_code` = 0, `cmd_done` = 0, `cpu_stall` = 0, synchronizer and accepted pattern = 3'b111, counters 0. The `mem_*` outputs follow the `cpu_*` inputs.
- **Reset mid-operation:** a pending command is discarded and not written after reset.

## Timing
- Processor path: zero latency (combinational through the mux).
- Button latency with the processor idle: a raw `btn` change stable at cycle t gives `mem_we` for the mailbox at cycle t + 2 + `DEBOUNCE_CYCLES` + 1.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no command.
- A grant happens in the first PEND cycle with `cpu_we` = 0. Back-to-back processor writes delay it indefinitely unless the starvation guard is compiled in.
- `cmd_done` is high exactly one cycle per mailbox write.

## Configuration
- Macro: `FILTER_CMD_STARVE_GUARD_EN`.
- **Defined:**
  - A wait counter counts cycles spent in PEND.
  - When it reaches `MAX_WAIT`, `cpu_stall` is asserted combinationally and the mailbox write is granted that cycle regardless of `cpu_we`. The processor write is not performed and must be held.
  - The counter clears on grant.
- **Undefined:** `cpu_stall` is tied to 0, no wait counter exists, and `MAX_WAIT` is unused.

## Structure
- **Package `filter_cmd_pkg`:**
  - State enum (IDLE, PEND, HOLD).
  - Code constants FILT_BYPASS = 0, FILT_1 = 1, FILT_2 = 2.
  - Button pattern constants BTN_F1 = 3'b110, BTN_F2 = 3'b101, BTN_BYP = 3'b011, BTN_REL = 3'b111.
  - Default mailbox address 10000.
- **Sub-module `btn_debounce`:** synchronizer plus stability counter, parameterized by `DEBOUNCE_CYCLES`. Outputs the accepted pattern.

## Test plan
- Reset, then hold `btn` = 3'b110 for 40 cycles with `DEBOUNCE_CYCLES` = 16 and `cpu_we` = 0 → one mailbox write at addr 10000, data 1, 19 cycles after the press. `cmd_code` = 1 and `cmd_done` pulses once.
- 3'b101 glitch lasting 10 cycles → no `mem_we`; `cmd_code` stays 0.
- Press 3'b101 while `cpu_we` = 1 continuously for 30 cycles → the processor writes pass unchanged. The mailbox write (data 2) occurs in the first cycle `cpu_we` = 0.
- Hold 3'b110, change to 3'b011 without release, then release to 3'b111 and press 3'b011 → exactly two writes, data 1 then data 0.
- With `FILTER_CMD_STARVE_GUARD_EN` and `MAX_WAIT` = 64, press 3'b110 under continuous `cpu_we` = 1 → `cpu_stall` high for one cycle, 64 cycles into PEND, with the mailbox write in that cycle.
- Assert `rst_n` = 0 during PEND, then release reset with buttons at 3'b111 → no mailbox write; all outputs at reset values.
